// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM state enum, opcode values and datapath mux/ALU-class encodings.
package mips_ctrl_pkg;

  localparam int STATE_W   = 4;
  localparam int ALU_CLS_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_R_EXEC   = 4'd3,
    S_R_WB     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALU_CLS_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [ALU_CLS_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [ALU_CLS_W-1:0] ALU_RFUNCT = 3'b010;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-word decoder: registered FSM state -> datapath strobes.
// Only FETCH looks at memAck, to qualify the IR/PC load.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0]   stateBits,
  input  logic                 memAck,
  output logic                 pcWrite,
  output logic                 pcWriteCond,
  output logic                 iord,
  output logic                 memRead,
  output logic                 memWrite,
  output logic                 irWrite,
  output logic                 regDst,
  output logic                 memToReg,
  output logic                 regWrite,
  output logic                 aluSrcA,
  output logic [1:0]           aluSrcB,
  output logic [ALU_CLS_W-1:0] aluOp,
  output logic [1:0]           pcSource,
  output logic                 busy
);

  state_t state;
  assign state = state_t'(stateBits);

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iord        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = SRCB_B;
    aluOp       = ALU_ADD;
    pcSource    = PCSRC_ALU;
    busy        = (state != S_IDLE);
    case (state)
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        irWrite = memAck;
        pcWrite = memAck;
      end
      // Speculative branch target is formed here so BRANCH only needs the compare.
      S_DECODE: aluSrcB = SRCB_IMMSH;
      S_R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_RFUNCT;
      end
      S_R_WB: begin
        regDst   = 1'b1;
        regWrite = 1'b1;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        memRead = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WB: begin
        memToReg = 1'b1;
        regWrite = 1'b1;
      end
      S_MEM_WR: begin
        memWrite = 1'b1;
        iord     = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = ALU_SUB;
        pcWriteCond = 1'b1;
        pcSource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcWrite  = 1'b1;
        pcSource = PCSRC_JUMP;
      end
      S_I_WB: regWrite = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory-wait handshake and retired-instruction counter.
// Optional macro MIPS_CTRL_TRAP_EN: unknown opcodes trap (sticky illegal_op) instead of acting as NOP.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               busy,
  output logic [CNT_W-1:0]   instr_retired,
  output logic               illegal_op
);

  state_t                 state;
  state_t                 stateNext;
  logic                   retire;
  logic [CNT_W-1:0]       retiredCnt;
  logic [ALU_CLS_W-1:0]   aluOpCls;
  logic                   isR, isLw, isSw, isBeq, isAddi, isJ;
  logic                   unusedZero;

  // The branch decision is taken in the datapath via pc_write_cond.
  assign unusedZero = zero;

  assign isR    = (op == OP_W'(OP_RTYPE));
  assign isLw   = (op == OP_W'(OP_LW));
  assign isSw   = (op == OP_W'(OP_SW));
  assign isBeq  = (op == OP_W'(OP_BEQ));
  assign isAddi = (op == OP_W'(OP_ADDI));
  assign isJ    = (op == OP_W'(OP_J));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:     stateNext = S_FETCH;
      S_FETCH:    if (mem_ack) stateNext = S_DECODE;
      S_DECODE: begin
        if (isR)              stateNext = S_R_EXEC;
        else if (isLw || isSw) stateNext = S_MEM_ADDR;
        else if (isBeq)       stateNext = S_BRANCH;
        else if (isAddi)      stateNext = S_I_EXEC;
        else if (isJ)         stateNext = S_JUMP;
        else begin
`ifdef MIPS_CTRL_TRAP_EN
          stateNext = S_TRAP;
`else
          stateNext = S_FETCH;
`endif
        end
      end
      S_R_EXEC:   stateNext = S_R_WB;
      S_R_WB:     stateNext = S_FETCH;
      S_MEM_ADDR: stateNext = isLw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ack) stateNext = S_MEM_WB;
      S_MEM_WB:   stateNext = S_FETCH;
      S_MEM_WR:   if (mem_ack) stateNext = S_FETCH;
      S_BRANCH:   stateNext = S_FETCH;
      S_JUMP:     stateNext = S_FETCH;
      S_I_EXEC:   stateNext = S_I_WB;
      S_I_WB:     stateNext = S_FETCH;
      S_TRAP:     stateNext = S_TRAP;
      default:    stateNext = S_IDLE;
    endcase
  end

  // Any return to FETCH from a later state completes an instruction; IDLE->FETCH does not.
  assign retire = (stateNext == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst)         retiredCnt <= '0;
    else if (retire) retiredCnt <= retiredCnt + CNT_W'(1);
  end

  assign instr_retired = retiredCnt;

  mips_ctrl_outdec uOutDec (
    .stateBits   (state),
    .memAck      (mem_ack),
    .pcWrite     (pc_write),
    .pcWriteCond (pc_write_cond),
    .iord        (iord),
    .memRead     (mem_read),
    .memWrite    (mem_write),
    .irWrite     (ir_write),
    .regDst      (reg_dst),
    .memToReg    (mem_to_reg),
    .regWrite    (reg_write),
    .aluSrcA     (alu_src_a),
    .aluSrcB     (alu_src_b),
    .aluOp       (aluOpCls),
    .pcSource    (pc_source),
    .busy        (busy)
  );

  assign alu_op = ALUOP_W'(aluOpCls);

`ifdef MIPS_CTRL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`else
  assign illegal_op = 1'b0;
`endif

endmodule
